// File: rtl/periph_bus_arbiter.sv
// Peripheral bus arbiter: the CPU data port (M0) and a secondary master
// (M1, DMA/debug) share one zero-latency peripheral/data-memory bus.
// M0 normally wins. M1 gets the bus when M0 is idle, when M1 has been
// starved for MAX_WAIT cycles (one beat only), or while M1 holds a locked
// burst of at most BURST_MAX beats.
module periph_bus_arbiter #(
   parameter int MAX_WAIT  = 4,
   parameter int BURST_MAX = 8
) (
   input  logic        cpu_clk,
   input  logic        reset,
   input  logic        m0_rd,
   input  logic        m0_wr,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic [31:0] m0_rdata,
   output logic        m0_stall,
   input  logic        m1_req,
   input  logic        m1_rd,
   input  logic        m1_wr,
   input  logic        m1_lock,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic [31:0] m1_rdata,
   output logic        m1_ack,
   output logic        rd,
   output logic        wr,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   input  logic [31:0] rdata
);

   localparam int WW = $clog2(MAX_WAIT + 2);
   localparam int BW = $clog2(BURST_MAX + 2);

   typedef enum logic {
      IDLE,
      M1_LOCK
   } state_t;

   state_t          state;
   logic [WW-1:0]   wait_cnt;
   logic [BW-1:0]   beat_cnt;
   logic            yield_m0;

   logic            m0_req;
   logic            starve;
   logic            hold_off;
   logic            gnt0;
   logic            gnt1;
   logic            last_beat;

   // Grant decision; everything is gated by reset so no beat is issued while
   // reset is held, and a pending forced yield keeps M1 off the bus for M0.
   always_comb begin
      m0_req    = m0_rd | m0_wr;
      starve    = (wait_cnt >= WW'(MAX_WAIT));
      hold_off  = yield_m0 & m0_req;
      gnt1      = reset & m1_req & ~hold_off
                  & (~m0_req | starve | (state == M1_LOCK));
      gnt0      = reset & m0_req & ~gnt1;
      last_beat = (beat_cnt >= BW'(BURST_MAX - 1));
   end

   // Bus mux: the granted master drives the shared bus in the same cycle;
   // an M1 read+write collapses to a write so a read side effect never fires.
   always_comb begin
      rd       = 1'b0;
      wr       = 1'b0;
      addr     = 32'd0;
      wdata    = 32'd0;
      m0_rdata = 32'd0;
      m1_rdata = 32'd0;
      if (gnt1) begin
         rd       = m1_rd & ~m1_wr;
         wr       = m1_wr;
         addr     = m1_addr;
         wdata    = m1_wdata;
         m1_rdata = rdata;
      end else if (gnt0) begin
         rd       = m0_rd;
         wr       = m0_wr;
         addr     = m0_addr;
         wdata    = m0_wdata;
         m0_rdata = rdata;
      end
      m0_stall = m0_req & ~gnt0;
      m1_ack   = gnt1;
   end

   // Starvation counter, burst lock FSM and the one-cycle M0 yield after a
   // burst is cut off at BURST_MAX beats.
   always_ff @(posedge cpu_clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         wait_cnt <= '0;
         beat_cnt <= '0;
         yield_m0 <= 1'b0;
      end else begin
         yield_m0 <= 1'b0;

         if (m1_req && !gnt1) begin
            if (!starve) begin
               wait_cnt <= wait_cnt + WW'(1);
            end
         end else begin
            wait_cnt <= '0;
         end

         case (state)
            IDLE: begin
               if (gnt1 && m1_lock) begin
                  if (BURST_MAX <= 1) begin
                     yield_m0 <= 1'b1;
                  end else begin
                     state    <= M1_LOCK;
                     beat_cnt <= BW'(1);
                  end
               end
            end
            M1_LOCK: begin
               if (!m1_req || !m1_lock) begin
                  state    <= IDLE;
                  beat_cnt <= '0;
               end else if (last_beat) begin
                  state    <= IDLE;
                  beat_cnt <= '0;
                  yield_m0 <= 1'b1;
               end else begin
                  beat_cnt <= beat_cnt + BW'(1);
               end
            end
            default: begin
               state    <= IDLE;
               beat_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Testbench for periph_bus_arbiter: directed scenarios with literal
// expectations plus a long randomized run, every cycle compared against a
// behavioural model of the arbitration rules.
module tb_periph_bus_arbiter;

   localparam int MAX_WAIT  = 4;
   localparam int BURST_MAX = 8;

   logic        cpu_clk = 1'b0;
   logic        reset;
   logic        m0_rd, m0_wr;
   logic [31:0] m0_addr, m0_wdata;
   logic [31:0] m0_rdata;
   logic        m0_stall;
   logic        m1_req, m1_rd, m1_wr, m1_lock;
   logic [31:0] m1_addr, m1_wdata;
   logic [31:0] m1_rdata;
   logic        m1_ack;
   logic        rd, wr;
   logic [31:0] addr, wdata;
   logic [31:0] rdata;

   int checks = 0;
   int errors = 0;

   // Behavioural model state: how long M1 has been waiting, whether it owns
   // the bus as a burst and how many more beats that burst may take, and
   // whether M0 is owed a turn after a burst was cut off.
   int mWait = 0;
   bit mLocked = 0;
   int mLeft = 0;
   bit mYield = 0;
   int nWait;
   bit nLocked;
   int nLeft;
   bit nYield;
   bit eG0, eG1;

   // Outputs sampled mid-cycle for the directed checks.
   logic        sRd, sWr, sStall, sAck;
   logic [31:0] sAddr, sM0Rdata, sM1Rdata, sRdata;

   periph_bus_arbiter #(.MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)) dut (
      .cpu_clk(cpu_clk), .reset(reset),
      .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_rdata(m0_rdata), .m0_stall(m0_stall),
      .m1_req(m1_req), .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_lock(m1_lock),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
      .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata)
   );

   always #5 cpu_clk = ~cpu_clk;

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic r0, input logic w0,
                                input logic [31:0] a0, input logic [31:0] d0,
                                input logic q1, input logic r1, input logic w1,
                                input logic l1, input logic [31:0] a1, input logic [31:0] d1);
      reset    = rst;
      m0_rd    = r0;
      m0_wr    = w0;
      m0_addr  = a0;
      m0_wdata = d0;
      m1_req   = q1;
      m1_rd    = r1;
      m1_wr    = w1;
      m1_lock  = l1;
      m1_addr  = a1;
      m1_wdata = d1;
      rdata    = $urandom;
   endtask

   task automatic idleStimulus();
      applyStimulus(1'b1, 0, 0, 32'd0, 32'd0, 0, 0, 0, 0, 32'd0, 32'd0);
   endtask

   // Who owns the bus this cycle and what the model looks like next cycle.
   task automatic computeExpect();
      bit m0r;
      m0r = m0_rd | m0_wr;
      if (!reset) begin
         eG1 = 0;
         eG0 = 0;
      end else begin
         eG1 = m1_req && (!m0r || mLocked || (mWait >= MAX_WAIT && !mYield));
         eG0 = m0r && !eG1;
      end
      nYield  = 0;
      nLocked = mLocked;
      nLeft   = mLeft;
      if (!reset) begin
         nWait   = 0;
         nLocked = 0;
         nLeft   = 0;
      end else begin
         nWait = (m1_req && !eG1) ? ((mWait + 1 > MAX_WAIT) ? MAX_WAIT : mWait + 1) : 0;
         if (mLocked) begin
            if (!m1_req || !m1_lock) begin
               nLocked = 0;
            end else if (mLeft == 1) begin
               nLocked = 0;
               nYield  = 1;
            end else begin
               nLeft = mLeft - 1;
            end
         end else if (eG1 && m1_lock) begin
            if (BURST_MAX - 1 == 0) begin
               nYield = 1;
            end else begin
               nLocked = 1;
               nLeft   = BURST_MAX - 1;
            end
         end
      end
   endtask

   task automatic checkOutput();
      logic [31:0] eAddr, eWdata;
      logic        eRd, eWr;
      eRd = 0; eWr = 0; eAddr = 0; eWdata = 0;
      if (eG1) begin
         eWr = m1_wr; eRd = m1_rd && !m1_wr; eAddr = m1_addr; eWdata = m1_wdata;
      end else if (eG0) begin
         eWr = m0_wr; eRd = m0_rd; eAddr = m0_addr; eWdata = m0_wdata;
      end
      checkVal("rd", {31'd0, rd}, {31'd0, eRd});
      checkVal("wr", {31'd0, wr}, {31'd0, eWr});
      checkVal("addr", addr, eAddr);
      checkVal("wdata", wdata, eWdata);
      checkVal("m0_rdata", m0_rdata, eG0 ? rdata : 32'd0);
      checkVal("m1_rdata", m1_rdata, eG1 ? rdata : 32'd0);
      checkVal("m0_stall", {31'd0, m0_stall}, {31'd0, (m0_rd | m0_wr) & ~eG0});
      checkVal("m1_ack", {31'd0, m1_ack}, {31'd0, eG1});
   endtask

   // One bus cycle: inputs are already driven; compare mid-cycle, then let
   // the clock edge advance both DUT and model.
   task automatic runCycle();
      #1;
      computeExpect();
      checkOutput();
      sRd = rd; sWr = wr; sStall = m0_stall; sAck = m1_ack; sAddr = addr;
      sM0Rdata = m0_rdata; sM1Rdata = m1_rdata; sRdata = rdata;
      @(posedge cpu_clk);
      mWait   = nWait;
      mLocked = nLocked;
      mLeft   = nLeft;
      mYield  = nYield;
      @(negedge cpu_clk);
   endtask

   initial begin
      logic [10:0] ackSeq;
      int          pulses;
      bit          done;

      // Reset held with M0 requesting: nothing on the bus, M0 stalled.
      applyStimulus(1'b0, 1, 0, 32'h4000_0000, 32'd0, 1, 1, 0, 0, 32'h4000_0004, 32'd0);
      runCycle();
      checkVal("reset_rd", {31'd0, sRd}, 32'd0);
      checkVal("reset_stall", {31'd0, sStall}, 32'd1);
      checkVal("reset_ack", {31'd0, sAck}, 32'd0);
      checkVal("reset_m1_rdata", sM1Rdata, 32'd0);
      idleStimulus();
      runCycle();

      // M0 read alone goes straight through in the same cycle.
      applyStimulus(1'b1, 1, 0, 32'h4000_0010, 32'd0, 0, 0, 0, 0, 32'd0, 32'd0);
      rdata = 32'hDEAD_BEEF;
      runCycle();
      checkVal("m0_alone_rd", {31'd0, sRd}, 32'd1);
      checkVal("m0_alone_addr", sAddr, 32'h4000_0010);
      checkVal("m0_alone_rdata", sM0Rdata, 32'hDEAD_BEEF);
      checkVal("m0_alone_stall", {31'd0, sStall}, 32'd0);
      idleStimulus();
      runCycle();

      // Continuous contention: M0 four beats, M1 forced through on the fifth,
      // then M0 again because the wait count restarted.
      ackSeq = '0;
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1'b1, 1, 0, 32'h1000_0000 + c, 32'd0, 1, 1, 0, 0, 32'h2000_0000, 32'd0);
         runCycle();
         ackSeq = {ackSeq[9:0], sAck};
      end
      checkVal("starve_ack_pattern", {26'd0, ackSeq[5:0]}, 32'b000010);
      idleStimulus();
      runCycle();

      // Locked burst of ten beats with M0 joining: eight M1 beats, one M0
      // beat, then M1 continues.
      ackSeq = '0;
      done = 0;
      for (int c = 1; c <= 11; c++) begin
         applyStimulus(1'b1, (c >= 2) && !done, 0, 32'h1000_0100, 32'd0,
                       1, 1, 0, 1, 32'h3000_0000 + c, 32'd0);
         runCycle();
         if (eG0) done = 1;
         ackSeq = {ackSeq[9:0], sAck};
      end
      checkVal("burst_ack_pattern", {21'd0, ackSeq}, 32'b11111111011);
      idleStimulus();
      runCycle();

      // M1 read forced past a stalled M0 writer: exactly one read pulse.
      pulses = 0;
      done = 0;
      for (int c = 0; c < 7; c++) begin
         applyStimulus(1'b1, 0, 1, 32'h1000_0200, 32'h5555_0000, !done, 1, 0, 0,
                       32'h4000_0020, 32'd0);
         runCycle();
         if (sRd && sAddr == 32'h4000_0020) pulses++;
         if (sAck) begin
            checkVal("m1_read_rdata", sM1Rdata, sRdata);
            checkVal("m1_read_m0_rdata", sM0Rdata, 32'd0);
            checkVal("m1_read_m0_stall", {31'd0, sStall}, 32'd1);
         end
         if (eG1) done = 1;
      end
      checkVal("m1_read_pulses", pulses, 32'd1);
      idleStimulus();
      runCycle();

      // M1 read and write together becomes a plain write.
      applyStimulus(1'b1, 0, 0, 32'd0, 32'd0, 1, 1, 1, 0, 32'h4000_0030, 32'h1234_5678);
      runCycle();
      checkVal("rdwr_wr", {31'd0, sWr}, 32'd1);
      checkVal("rdwr_rd", {31'd0, sRd}, 32'd0);
      idleStimulus();
      runCycle();

      // Reset at beat three of a burst abandons it.
      for (int c = 1; c <= 3; c++) begin
         applyStimulus(c != 3, 0, 0, 32'd0, 32'd0, 1, 1, 0, 1, 32'h3000_1000 + c, 32'd0);
         runCycle();
      end
      checkVal("reset_beat_rd", {31'd0, sRd}, 32'd0);
      checkVal("reset_beat_wr", {31'd0, sWr}, 32'd0);
      checkVal("reset_beat_ack", {31'd0, sAck}, 32'd0);
      applyStimulus(1'b1, 1, 0, 32'h1000_0300, 32'd0, 1, 1, 0, 1, 32'h3000_2000, 32'd0);
      runCycle();
      checkVal("after_reset_ack", {31'd0, sAck}, 32'd0);
      checkVal("after_reset_stall", {31'd0, sStall}, 32'd0);
      idleStimulus();
      runCycle();

      // Randomized traffic, biased towards contention and locked bursts.
      for (int c = 0; c < 3000; c++) begin
         applyStimulus($urandom_range(99) != 0,
                       $urandom_range(9) < 4, $urandom_range(9) < 3,
                       $urandom, $urandom,
                       $urandom_range(9) < 7, $urandom_range(1) == 1, $urandom_range(3) == 0,
                       $urandom_range(9) < 6, $urandom, $urandom);
         runCycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/periph_bus_arbiter.md
PERIPH_BUS_ARBITER -- requirements
Module: periph_bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 4, meaning consecutive denied M1 cycles before M1 is forced through.
REQ-002 SHALL have parameter BURST_MAX, default 8, meaning maximum beats in one locked M1 burst.
REQ-003 SHALL have port cpu_clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports m0_rd, m0_wr  input  1 each  CPU data-port read/write strobes (master M0).
REQ-006 SHALL have ports m0_addr, m0_wdata  input  32 each  CPU address/write data.
REQ-007 SHALL have ports m0_rdata  output  32 and m0_stall  output  1  CPU read data and stall.
REQ-008 SHALL have ports m1_req, m1_rd, m1_wr, m1_lock  input  1 each  secondary master (DMA/debug) request, read, write, burst lock.
REQ-009 SHALL have ports m1_addr, m1_wdata  input  32 each  and m1_rdata  output  32, m1_ack  output  1  (beat accepted this cycle).
REQ-010 SHALL have ports rd, wr  output  1 each, addr, wdata  output  32 each, rdata  input  32  shared peripheral/data-memory bus.

Function
REQ-011 SHALL define m0_req = m0_rd | m0_wr; M1 requests only when m1_req=1.
REQ-012 SHALL have states IDLE and M1_LOCK plus registers wait_cnt (saturating at MAX_WAIT) and beat_cnt (0..BURST_MAX).
REQ-013 SHALL compute grant combinationally each cycle: gnt1 = m1_req & (~m0_req | starve | state==M1_LOCK); gnt0 = m0_req & ~gnt1; starve = (wait_cnt >= MAX_WAIT).
REQ-014 SHALL drive rd/wr/addr/wdata from the granted master in the same cycle; rd=wr=0, addr=wdata=0 when neither granted.
REQ-015 SHALL route rdata to the granted master's rdata port; non-granted master's rdata SHALL be 0.
REQ-016 SHALL assert m0_stall = m0_req & ~gnt0 and m1_ack = gnt1.
REQ-017 SHALL, when m1_rd and m1_wr are both 1, issue a write only (rd=0) to avoid duplicate read side effects.
REQ-018 SHALL forward each granted beat exactly once; a stalled master's request SHALL NOT reach the bus (destructive reads, e.g. UART status clear, occur once).
REQ-019 SHALL increment wait_cnt on m1_req & ~gnt1, clear it on gnt1 or ~m1_req; starvation override grants exactly one beat.
REQ-020 SHALL go IDLE->M1_LOCK when gnt1 & m1_lock; beat_cnt counts granted beats including the first.
REQ-021 SHALL in M1_LOCK return to IDLE on ~m1_req, on ~m1_lock at a granted beat, or when beat_cnt reaches BURST_MAX.
REQ-022 SHALL, after a BURST_MAX-forced release, give M0 priority for at least one cycle (no immediate re-lock if m0_req=1).
REQ-023 SHALL let zero-latency combinational paths only run address/data/strobes; no registered delay on the bus.

Reset
REQ-024 SHALL on reset=0 force state=IDLE, wait_cnt=0, beat_cnt=0 asynchronously.
REQ-025 SHALL hold rd=wr=0, m1_ack=0, m0_stall=m0_req, rdata outputs 0 while reset=0.
REQ-026 SHALL abandon any burst in progress on reset mid-operation; no beat SHALL be issued in the reset cycle.

Verification
REQ-027 SHALL cover: M0 read 0x40000010 alone -> rd=1, addr=0x40000010, m0_rdata=rdata, m0_stall=0 same cycle.
REQ-028 SHALL cover: M0 and M1 request continuously, MAX_WAIT=4 -> M0 granted 4 cycles, M1 ack on 5th, wait_cnt back to 0.
REQ-029 SHALL cover: M1 lock burst of 10 beats, BURST_MAX=8, M0 requesting -> 8 M1 acks, 1 M0 beat, then M1 resumes.
REQ-030 SHALL cover: M1 read 0x40000020 while M0 stalled -> exactly one rd pulse to that address, m1_rdata valid, m0_rdata=0.
REQ-031 SHALL cover: m1_rd=m1_wr=1 -> wr=1, rd=0; and reset asserted at beat 3 of a burst -> state IDLE, no bus strobe that cycle.
